// File: rtl/flick_pkg.sv
// Shared types and widths for the push-button input conditioner.
package flick_pkg;

   localparam int unsigned GLITCH_W = 8;
   localparam int unsigned DCNT_W   = 8;
   localparam int unsigned HCNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
      return (&v) ? v : v + GLITCH_W'(1);
   endfunction

endpackage

// File: rtl/flick_sync.sv
// Multi-flop synchroniser that brings the raw button level into the CLK domain.
module flick_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_s;

   always_ff @(posedge CLK) begin
      if (RST) r_s <= '0;
      else     r_s <= {r_s[SYNC_STAGES-2:0], i_d};
   end

   assign o_q = r_s[SYNC_STAGES-1];

endmodule

// File: rtl/flick_conditioner.sv
// Debounces a raw button into a one-shot FLICK, a clean level, a long-press
// pulse and a saturating count of rejected transitions.
module flick_conditioner
   import flick_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES     = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                BTN_RAW,
   output logic                FLICK,
   output logic                FLICK_LVL,
   output logic                LONG_PRESS,
   output logic [GLITCH_W-1:0] GLITCH_CNT
);

   localparam logic [DCNT_W-1:0] DC_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HCNT_W-1:0] HC_MAX  = HCNT_W'(HOLD_CYCLES);
   localparam logic [HCNT_W-1:0] HC_LAST = HCNT_W'(HOLD_CYCLES - 1);

   logic                w_sync;
   state_t              r_state;
   logic [DCNT_W-1:0]   r_dcnt;
   logic [HCNT_W-1:0]   r_hcnt;
   logic                r_flick;
   logic                r_lvl;
   logic                r_long;
   logic [GLITCH_W-1:0] r_glitch;

   flick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .CLK (CLK),
      .RST (RST),
      .i_d (BTN_RAW),
      .o_q (w_sync)
   );

   // dcnt counts consecutive samples of the new level; hcnt counts settled-press time.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= IDLE;
         r_dcnt   <= '0;
         r_hcnt   <= '0;
         r_flick  <= 1'b0;
         r_lvl    <= 1'b0;
         r_long   <= 1'b0;
         r_glitch <= '0;
      end else begin
         r_flick <= 1'b0;
         r_long  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_sync) begin
                  r_state <= PRESS_WAIT;
                  r_dcnt  <= DCNT_W'(1);
               end
            end
            PRESS_WAIT: begin
               if (w_sync) begin
                  if (r_dcnt == DC_LAST) begin
                     r_state <= PRESSED;
                     r_flick <= 1'b1;
                     r_lvl   <= 1'b1;
                     r_hcnt  <= '0;
                  end else begin
                     r_dcnt <= r_dcnt + DCNT_W'(1);
                  end
               end else begin
                  r_state  <= IDLE;
                  r_dcnt   <= '0;
                  r_glitch <= sat_inc(r_glitch);
               end
            end
            PRESSED: begin
               // Saturating at the threshold makes the long press one-shot.
               if (r_hcnt != HC_MAX) begin
                  r_hcnt <= r_hcnt + HCNT_W'(1);
                  if (r_hcnt == HC_LAST) r_long <= 1'b1;
               end
               if (!w_sync) begin
                  r_state <= RELEASE_WAIT;
                  r_dcnt  <= DCNT_W'(1);
               end
            end
            RELEASE_WAIT: begin
               if (!w_sync) begin
                  if (r_dcnt == DC_LAST) begin
                     r_state <= IDLE;
                     r_lvl   <= 1'b0;
                     r_dcnt  <= '0;
                  end else begin
                     r_dcnt <= r_dcnt + DCNT_W'(1);
                  end
               end else begin
                  r_state  <= PRESSED;
                  r_glitch <= sat_inc(r_glitch);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign FLICK      = r_flick;
   assign FLICK_LVL  = r_lvl;
   assign LONG_PRESS = r_long;
   assign GLITCH_CNT = r_glitch;

endmodule

// File: tb/tb_flick_conditioner.sv
// Randomised and directed bench for flick_conditioner against a run-length model.
module tb_flick_conditioner;

   localparam int unsigned SYNC = 2;
   localparam int unsigned DEB  = 4;
   localparam int unsigned HOLD = 16;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       BTN_RAW = 1'b0;
   logic       FLICK, FLICK_LVL, LONG_PRESS;
   logic [7:0] GLITCH_CNT;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   flick_conditioner #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)
   ) dut (
      .CLK(CLK), .RST(RST), .BTN_RAW(BTN_RAW), .FLICK(FLICK),
      .FLICK_LVL(FLICK_LVL), .LONG_PRESS(LONG_PRESS), .GLITCH_CNT(GLITCH_CNT)
   );

   always #5 CLK = ~CLK;

   function automatic void check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endfunction

   // Model: the raw level is delayed SYNC edges, then a run of DEB identical
   // opposite-level samples flips the accepted level; an interrupted run is a glitch.
   logic [SYNC-1:0] hist;
   bit  m_valid = 0;
   bit  m_lvl, m_flick, m_long;
   int  m_run, m_hold, m_glitch;

   always @(posedge CLK) begin
      if (RST) begin
         hist = '0; m_lvl = 0; m_run = 0; m_hold = 0; m_glitch = 0;
         m_flick = 0; m_long = 0; m_valid = 1;
      end else begin
         bit v;
         bit settled_press;
         v = hist[SYNC-1];
         hist = {hist[SYNC-2:0], BTN_RAW};
         m_flick = 0; m_long = 0;
         settled_press = m_lvl && (m_run == 0);
         if (settled_press && m_hold < HOLD) begin
            m_hold++;
            if (m_hold == HOLD) m_long = 1;
         end
         if (v != m_lvl) begin
            m_run++;
            if (m_run == DEB) begin
               m_lvl = v;
               m_run = 0;
               if (v) begin m_flick = 1; m_hold = 0; end
            end
         end else if (m_run > 0) begin
            m_run = 0;
            if (m_glitch < 255) m_glitch++;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, sampled mid-cycle.
   always @(negedge CLK) begin
      if (m_valid) begin
         check("flick", int'(FLICK), int'(m_flick));
         check("flick_lvl", int'(FLICK_LVL), int'(m_lvl));
         check("long_press", int'(LONG_PRESS), int'(m_long));
         check("glitch_cnt", int'(GLITCH_CNT), m_glitch);
      end
   end

   task automatic do_reset();
      RST = 1'b1; BTN_RAW = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic hold_lvl(input bit v, input int n);
      BTN_RAW = v;
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      int flick_at, flick_n, fall_at, long_at, long_n;

      @(negedge CLK);
      do_reset();
      check("reset_flick", int'(FLICK), 0);
      check("reset_lvl", int'(FLICK_LVL), 0);
      check("reset_glitch", int'(GLITCH_CNT), 0);

      // Clean press: FLICK after E5, level falls 5 edges after first low sample.
      flick_at = -1; flick_n = 0; fall_at = -1;
      BTN_RAW = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         if (FLICK) begin flick_n++; if (flick_at < 0) flick_at = k; end
      end
      BTN_RAW = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         if (!FLICK_LVL && fall_at < 0) fall_at = k;
      end
      check("clean_flick_edge", flick_at, 5);
      check("clean_flick_count", flick_n, 1);
      check("clean_fall_edge", fall_at, 5);
      check("clean_glitch", int'(GLITCH_CNT), 0);

      // Press bounce, repeated until the glitch counter saturates.
      do_reset();
      flick_n = 0;
      for (int r = 0; r < 300; r++) begin
         hold_lvl(1'b1, 2);
         BTN_RAW = 1'b0;
         repeat (4) begin @(negedge CLK); if (FLICK) flick_n++; end
         if (r == 0) check("bounce_glitch_one", int'(GLITCH_CNT), 1);
      end
      check("bounce_glitch_sat", int'(GLITCH_CNT), 255);
      check("bounce_no_flick", flick_n, 0);
      check("bounce_lvl", int'(FLICK_LVL), 0);

      // Release bounce after an accepted press.
      do_reset();
      flick_n = 0;
      BTN_RAW = 1'b1;
      repeat (10) begin @(negedge CLK); if (FLICK) flick_n++; end
      hold_lvl(1'b0, 2);
      hold_lvl(1'b1, 3);
      BTN_RAW = 1'b0;
      repeat (12) begin @(negedge CLK); if (FLICK) flick_n++; end
      check("relbounce_flick_count", flick_n, 1);
      check("relbounce_glitch", int'(GLITCH_CNT), 1);
      check("relbounce_lvl", int'(FLICK_LVL), 0);

      // Long press fires once, after E21.
      do_reset();
      long_at = -1; long_n = 0;
      BTN_RAW = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (LONG_PRESS) begin long_n++; if (long_at < 0) long_at = k; end
      end
      hold_lvl(1'b0, 10);
      check("long_edge", long_at, 21);
      check("long_count", long_n, 1);

      // Short hold: no long press.
      long_n = 0;
      BTN_RAW = 1'b1;
      repeat (10) begin @(negedge CLK); if (LONG_PRESS) long_n++; end
      BTN_RAW = 1'b0;
      repeat (25) begin @(negedge CLK); if (LONG_PRESS) long_n++; end
      check("short_no_long", long_n, 0);

      // Reset at E3 of a held press; FLICK then at E9.
      do_reset();
      BTN_RAW = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("midrst_flick", int'(FLICK), 0);
      check("midrst_lvl", int'(FLICK_LVL), 0);
      flick_at = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         if (FLICK && flick_at < 0) flick_at = k;
      end
      check("midrst_flick_edge", flick_at, 5);

      // Reset during PRESSED at hcnt=10 suppresses that press's long press.
      hold_lvl(1'b0, 10);
      BTN_RAW = 1'b1;
      repeat (16) @(negedge CLK);
      RST = 1'b1; BTN_RAW = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      long_n = 0;
      repeat (30) begin @(negedge CLK); if (LONG_PRESS) long_n++; end
      check("pressrst_no_long", long_n, 0);
      check("pressrst_glitch", int'(GLITCH_CNT), 0);

      // Random bouncing with occasional resets.
      for (int s = 0; s < 400; s++) begin
         if ($urandom_range(0, 60) == 0) begin
            RST = 1'b1;
            @(negedge CLK);
            RST = 1'b0;
         end
         if ($urandom_range(0, 3) == 0) hold_lvl(1'($urandom_range(0, 1)), int'($urandom_range(20, 40)));
         else hold_lvl(1'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
      end
      hold_lvl(1'b0, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/flick_conditioner.md
Name: flick_conditioner

Overview:
- Upstream input stage for bound_flasher. Takes a raw, asynchronous, bouncing push-button level (BTN_RAW).
- Produces a clean single-cycle FLICK pulse, a debounced level, a one-shot long-press pulse and a saturating bounce counter.
- FLICK connects directly to bound_flasher.FLICK on the same CLK.

Parameters:
- SYNC_STAGES, 2: flops in the BTN_RAW synchroniser chain; legal range 2..4.
- DEBOUNCE_CYCLES, 4: consecutive identical synchronised samples needed to accept a level change; legal range 2..255.
- HOLD_CYCLES, 16: cycles in PRESSED before LONG_PRESS fires; legal range 2..65535.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- BTN_RAW  input  1  raw asynchronous button level; may bounce.
- FLICK  output  1  one-cycle pulse on accepted press.
- FLICK_LVL  output  1  debounced button level.
- LONG_PRESS  output  1  one-cycle pulse when the hold threshold is reached.
- GLITCH_CNT  output  8  saturating count of rejected transitions.

Behaviour:
- Reset: RST sampled high at a CLK edge clears the sync chain, state (IDLE), the debounce counter and the hold counter. After that edge FLICK=0, FLICK_LVL=0, LONG_PRESS=0, GLITCH_CNT=0. RST takes priority over all other inputs, including mid-press and mid-debounce.
- Sync: s[0]<=BTN_RAW, s[i]<=s[i-1]. The FSM observes only sync=s[SYNC_STAGES-1].
- States: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE: if sync=1 -> PRESS_WAIT, dcnt=1; else stay.
- PRESS_WAIT:
  - sync=1 and dcnt+1==DEBOUNCE_CYCLES -> PRESSED. Same edge: FLICK<=1, FLICK_LVL<=1, hcnt<=0.
  - sync=1 otherwise: dcnt++.
  - sync=0 -> IDLE, dcnt<=0, GLITCH_CNT++ (saturates at 255).
- PRESSED:
  - hcnt increments each cycle until it saturates at HOLD_CYCLES.
  - LONG_PRESS<=1 on the edge hcnt reaches HOLD_CYCLES. It fires exactly once per press, with no auto-repeat.
  - sync=0 -> RELEASE_WAIT, dcnt=1. hcnt holds its value during RELEASE_WAIT.
- RELEASE_WAIT:
  - sync=0 and dcnt+1==DEBOUNCE_CYCLES -> IDLE, FLICK_LVL<=0.
  - sync=0 otherwise: dcnt++.
  - sync=1 -> PRESSED, GLITCH_CNT++, hcnt resumes. No new FLICK.
- FLICK and LONG_PRESS are registered pulses and are cleared on the following edge.
- Latency: BTN_RAW first sampled high at edge E0 and held high -> FLICK is high after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1 for exactly one cycle. Release latency is symmetric for FLICK_LVL falling.
- LONG_PRESS is high after edge E_flick+HOLD_CYCLES, where E_flick is the edge that set FLICK.
- Button already held at reset release: it is debounced from IDLE as a fresh press and produces FLICK after full latency.
- Widths: dcnt is 8 bits; hcnt is 16 bits.

Decomposition:
- Package flick_pkg holds:
  - the state enum, binary encoding IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3;
  - GLITCH_W=8, DCNT_W=8, HCNT_W=16.
- One sub-module, flick_sync: parameterised SYNC_STAGES flop chain with synchronous active-high RST. It is instantiated once.
- FSM, counters and output registers live in flick_conditioner.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=16):
- Clean press: BTN_RAW 0->1 sampled at E0, held for 10 cycles, then 0 -> FLICK=1 only after E5; FLICK_LVL=1 after E5. FLICK_LVL=0 five edges after the first low sample. GLITCH_CNT=0.
- Press bounce: BTN_RAW high for 2 cycles, then low -> no FLICK, FLICK_LVL stays 0, GLITCH_CNT=1. Repeat 300 times -> GLITCH_CNT saturates at 255.
- Release bounce: after an accepted press, BTN_RAW low 2 cycles, high 3 cycles, then low steadily -> exactly one FLICK total, GLITCH_CNT=1, FLICK_LVL falls only after 4 consecutive low synchronised samples.
- Long press: hold BTN_RAW high for 40 cycles -> FLICK after E5, LONG_PRESS one cycle after E21, no second LONG_PRESS. A release after 10 cycles of hold -> no LONG_PRESS.
- Reset mid-debounce: RST=1 for one edge at E3 of a press, BTN_RAW still held -> all outputs 0 after the RST edge. FLICK then fires 5 edges after the first post-reset sampling edge (E4 -> E9).
- Reset during PRESSED at hcnt=10 -> LONG_PRESS never fires for that press. GLITCH_CNT=0 after reset.
